qspi_flash_reader: RTL

Memory-mapped, read-only Quad-SPI flash bridge. It is the slave on the crossbar's MEM output port and fills the TADDR_MEM_FLASH slot, replacing the zero-tied w_AV_FLASH_ReadData and w_AV_FLASH_WaitRequest. Each Avalon word read becomes one Quad Output Fast Read (0x6B) transaction on the user flash pins. The returned 32-bit word is held off with WaitRequest until it is complete.

---
 rtl/qspi_flash_reader_if.sv | 21 ++
 rtl/qspi_flash_reader.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/qspi_flash_reader_if.sv
// Avalon-MM word bus between the crossbar MEM port and the QSPI flash bridge.
// Member names keep the slave-side direction prefixes of the original ports.
interface qspi_flash_reader_if;
   logic [29:0] i_AV_Addr;
   logic [3:0]  i_AV_ByteEn;
   logic        i_AV_Read;
   logic        i_AV_Write;
   logic [31:0] i_AV_WriteData;
   logic [31:0] o_AV_ReadData;
   logic        o_AV_WaitRequest;

   modport master (
      output i_AV_Addr, i_AV_ByteEn, i_AV_Read, i_AV_Write, i_AV_WriteData,
      input  o_AV_ReadData, o_AV_WaitRequest
   );

   modport slave (
      input  i_AV_Addr, i_AV_ByteEn, i_AV_Read, i_AV_Write, i_AV_WriteData,
      output o_AV_ReadData, o_AV_WaitRequest
   );
endinterface

// File: rtl/qspi_flash_reader.sv
// Read-only memory-mapped Quad-SPI flash bridge. Every Avalon word read is
// turned into one Quad Output Fast Read (0x6B) transaction; the bus is
// stalled with WaitRequest until the 32-bit word has been assembled.
module qspi_flash_reader #(
   parameter int NUM_PERIPH_SEL_BITS = 3,
   parameter int PERIPH_SEL_VAL      = 0,
   parameter int DUMMY_CYCLES        = 8,
   parameter int CS_HIGH_CYCLES      = 2
) (
   input  logic              i_Clk,
   input  logic              i_nReset,
   qspi_flash_reader_if.slave io_AV,
   output logic              o_UserFlash_Clk,
   output logic              o_UserFlash_nCS,
   inout  wire  [3:0]        io_UserFlash_IO
);

   localparam logic [7:0] L_CMD_QOFR   = 8'h6B;
   localparam logic [7:0] L_CMD_LAST   = 8'd7;    // 8 command bits, also 8 data nibbles
   localparam logic [7:0] L_ADDR_LAST  = 8'd23;   // 24 address bits
   localparam logic [7:0] L_DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
   localparam logic [7:0] L_DESEL_LAST = 8'(CS_HIGH_CYCLES - 1);
   localparam logic [NUM_PERIPH_SEL_BITS-1:0] L_SEL_VAL =
      NUM_PERIPH_SEL_BITS'(PERIPH_SEL_VAL);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE, S_DESEL
   } state_t;

   state_t      r_state;
   logic [7:0]  r_cnt;     // SCK periods completed in the current phase
   logic        r_sck;
   logic        r_ncs;
   logic        r_io_oe;   // drive IO0 and IO3:2 (released for dummy/data)
   logic [31:0] r_tx;      // command + address, MSB goes out on IO0
   logic [31:0] r_rx;      // nibbles in arrival order: byte0 ends up in [31:24]

   logic        w_sel;
   logic        w_req;
   logic [7:0]  w_last;
   logic [31:0] w_word;
   logic        w_unused;

   assign w_sel = (io_AV.i_AV_Addr[29 -: NUM_PERIPH_SEL_BITS] == L_SEL_VAL);
   // A simultaneous write is ignored, so Read alone decides a request.
   assign w_req = w_sel & io_AV.i_AV_Read;

   // Lowest flash address byte arrives first and belongs in bits [7:0].
   assign w_word = {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};

   // Slave outputs are ORed on the bus, so both are zero unless we are addressed.
   assign io_AV.o_AV_WaitRequest = w_req & (r_state != S_DONE);
   assign io_AV.o_AV_ReadData    = (w_req && r_state == S_DONE) ? w_word : 32'd0;

   assign o_UserFlash_Clk = r_sck;
   assign o_UserFlash_nCS = r_ncs;

   // IO0 carries command/address; WP# and HOLD# are held high until the flash takes over the lines.
   assign io_UserFlash_IO[0] = r_io_oe ? r_tx[31] : 1'bz;
   assign io_UserFlash_IO[1] = 1'bz;
   assign io_UserFlash_IO[2] = r_io_oe ? 1'b1 : 1'bz;
   assign io_UserFlash_IO[3] = r_io_oe ? 1'b1 : 1'bz;

   // Byte enables and write data play no role in a read-only bridge.
   assign w_unused = ^{io_AV.i_AV_Addr, io_AV.i_AV_ByteEn, io_AV.i_AV_Write,
                       io_AV.i_AV_WriteData};

   // Number of SCK periods (minus one) spent in the current shifting phase.
   always_comb begin
      w_last = L_CMD_LAST;
      case (r_state)
         S_ADDR:  w_last = L_ADDR_LAST;
         S_DUMMY: w_last = L_DUMMY_LAST;
         default: w_last = L_CMD_LAST;
      endcase
   end

   // Transaction sequencer: SCK high phase lets the flash sample, the i_Clk
   // edge ending it captures the input nibble and advances IO0.
   always_ff @(posedge i_Clk or negedge i_nReset) begin
      if (!i_nReset) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
         r_sck   <= 1'b0;
         r_ncs   <= 1'b1;
         r_io_oe <= 1'b1;
         r_tx    <= 32'd0;
         r_rx    <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_state <= S_START;
                  r_ncs   <= 1'b0;
                  r_tx    <= {L_CMD_QOFR, io_AV.i_AV_Addr[21:0], 2'b00};
                  r_rx    <= 32'd0;
               end
            end
            S_START: begin
               // Command MSB has been set up for one cycle; first rising edge next.
               r_sck   <= 1'b1;
               r_cnt   <= 8'd0;
               r_state <= S_CMD;
            end
            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
               if (r_sck) begin
                  r_sck <= 1'b0;
                  r_tx  <= {r_tx[30:0], 1'b0};
                  if (r_state == S_DATA) begin
                     r_rx <= {r_rx[27:0], io_UserFlash_IO};
                  end
               end else if (r_cnt == w_last) begin
                  r_cnt <= 8'd0;
                  case (r_state)
                     S_CMD: begin
                        r_sck   <= 1'b1;
                        r_state <= S_ADDR;
                     end
                     S_ADDR: begin
                        r_sck   <= 1'b1;
                        r_io_oe <= 1'b0;
                        r_state <= S_DUMMY;
                     end
                     S_DUMMY: begin
                        r_sck   <= 1'b1;
                        r_state <= S_DATA;
                     end
                     default: begin
                        r_ncs   <= 1'b1;
                        r_state <= S_DONE;
                     end
                  endcase
               end else begin
                  r_sck <= 1'b1;
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_DONE: begin
               // Word is presented this cycle whether or not the master still waits.
               r_io_oe <= 1'b1;
               r_tx    <= 32'd0;
               r_cnt   <= 8'd0;
               if (CS_HIGH_CYCLES == 0) begin
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_DESEL;
               end
            end
            S_DESEL: begin
               if (r_cnt == L_DESEL_LAST) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
